// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: core load/store to req/ack data bus.
// Handles lane placement, load extension, stall and fault reporting.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memDataIn,
  input  logic [2:0]  memSize,
  output logic [31:0] memDataOut,
  output logic        memBusy,
  output logic        memDone,
  output logic        memFault,
  output logic [1:0]  faultCause,
  output logic [31:0] faultAddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_e;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_TMO  = 2'b10;
  localparam logic [1:0] C_ILL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        cause_q;
  logic [31:0]       rdata_q;
  logic [31:0]       faddr_q;
  logic              done_q;
  logic              fault_q;
  logic              breq_q;
  logic              bwe_q;
  logic [31:0]       baddr_q;
  logic [31:0]       bwdata_q;
  logic [3:0]        bbe_q;

  logic              req_any;
  logic              ill_d;
  logic              mis_d;
  logic [1:0]        cause_d;
  logic [31:0]       wdata_d;
  logic [3:0]        be_d;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_d;

  assign req_any = memRead | memWrite;

  assign ill_d = (memRead & memWrite)
               | (memSize == 3'b011)
               | (memSize[2] & memSize[1]);

  assign mis_d = ((memSize[1:0] == 2'b01) & memAddr[0])
               | ((memSize[1:0] == 2'b10) & (|memAddr[1:0]));

  always_comb begin
    cause_d = C_NONE;
    if (ill_d) begin
      cause_d = C_ILL;
    end else if (mis_d) begin
      cause_d = C_MIS;
    end
  end

  // Stores replicate the datum so any lane selected by be carries it.
  always_comb begin
    wdata_d = memDataIn;
    be_d    = 4'b1111;
    if (memWrite) begin
      unique case (1'b1)
        memSize[1:0] == 2'b00: begin
          wdata_d = {4{memDataIn[7:0]}};
          be_d    = 4'b0001 << memAddr[1:0];
        end
        memSize[1:0] == 2'b01: begin
          wdata_d = {2{memDataIn[15:0]}};
          be_d    = memAddr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = memDataIn;
          be_d    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   rd_byte = bus_rdata[7:0];
      2'b01:   rd_byte = bus_rdata[15:8];
      2'b10:   rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
  end

  assign rd_half = addr_q[1] ? bus_rdata[31:16]
                             : bus_rdata[15:0];

  always_comb begin
    unique case (size_q)
      3'b000:  load_d = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_d = {24'h0, rd_byte};
      3'b001:  load_d = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_d = {16'h0, rd_half};
      default: load_d = bus_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      cause_q  <= C_NONE;
      rdata_q  <= '0;
      faddr_q  <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      bbe_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_any) begin
            addr_q  <= memAddr;
            size_q  <= memSize;
            we_q    <= memWrite;
            cause_q <= cause_d;
            cnt_q   <= '0;
            if (cause_d != C_NONE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              faddr_q <= memAddr;
            end else begin
              state_q  <= S_BUS;
              breq_q   <= 1'b1;
              bwe_q    <= memWrite;
              baddr_q  <= {memAddr[31:2], 2'b00};
              bwdata_q <= wdata_d;
              bbe_q    <= be_d;
            end
          end
        end
        S_BUS: begin
          // Ack is checked first so it wins on the limit cycle.
          if (bus_ack) begin
            state_q <= S_DONE;
            breq_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= load_d;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            breq_q  <= 1'b0;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            cause_q <= C_TMO;
            faddr_q <= addr_q;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      S_IDLE:  memBusy = req_any;
      S_BUS:   memBusy = 1'b1;
      default: memBusy = 1'b0;
    endcase
  end

  assign memDataOut = rdata_q;
  assign memDone    = done_q;
  assign memFault   = fault_q;
  assign faultCause = cause_q;
  assign faultAddr  = faddr_q;
  assign bus_req    = breq_q;
  assign bus_we     = bwe_q;
  assign bus_addr   = baddr_q;
  assign bus_wdata  = bwdata_q;
  assign bus_be     = bbe_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory access controller directly downstream of the CPU core's memory stage.
- Accepts the core's load/store request (address, store data, funct3 size code) and runs one transaction on a simple req/ack on-chip data bus.
- Store path: byte-lane placement and byte enables. Load path: lane extraction with sign/zero extension.
- Provides a stall signal to the core, plus alignment, illegal-request and timeout fault reporting.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for bus_ack before aborting; legal range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RES  in  1  reset, asynchronous, active-low.
- memRead  in  1  load request from core.
- memWrite  in  1  store request from core.
- memAddr  in  32  byte address.
- memDataIn  in  32  store data from core, right-aligned.
- memSize  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- memDataOut  out  32  load result, extended.
- memBusy  out  1  core stall request.
- memDone  out  1  one-cycle completion pulse.
- memFault  out  1  asserted with memDone when the access failed.
- faultCause  out  2  fault code: 00 none, 01 misaligned, 10 timeout, 11 illegal.
- faultAddr  out  32  address of the last faulting request.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; bits [1:0] are forced to 00.
- bus_wdata  out  32  lane-placed write data.
- bus_be  out  4  byte enables.
- bus_rdata  in  32  read data; valid when bus_ack = 1.
- bus_ack  in  1  transaction complete.

Behaviour:
- Reset (RES = 0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including memDataOut, faultAddr, bus_addr and bus_be.
  - The timeout counter clears.
  - An in-flight bus transaction is dropped with no memDone pulse.
- The FSM has three states: IDLE, BUS, DONE.
- IDLE:
  - memBusy is combinationally equal to (memRead | memWrite).
  - At the clock edge where a request is seen, address, data, size and direction are captured.
- Request checks in IDLE, in priority order:
  1. memRead & memWrite, or an unsupported memSize (011, 110, 111), gives cause 11.
  2. A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 00, gives cause 01.
  3. Otherwise the request is legal and the FSM goes to BUS.
- A faulting request goes directly to DONE, with no bus activity.
- BUS:
  - bus_req = 1, memBusy = 1.
  - bus_we, bus_addr, bus_wdata and bus_be are registered and held stable until bus_ack.
- bus_ack = 1 in BUS:
  - Go to DONE.
  - For a read, register the extracted data into memDataOut.
  - The counter increments on every BUS cycle without ack.
- Timeout: when the counter reaches TIMEOUT_CYCLES - 1 with no ack:
  - Drop bus_req and go to DONE.
  - cause = 10, memDataOut = 0.
- DONE lasts exactly one cycle:
  - memDone = 1, memBusy = 0.
  - memFault = (cause ≠ 00).
  - On a fault, faultAddr = the captured address.
  - Then return to IDLE.
- faultCause holds its value until the next request is accepted, which clears it to 00. memDataOut holds until the next load completes.
- Latency: if bus_ack arrives in the first BUS cycle, the request is seen at edge N, bus_req is high in cycle N+1, and memDone is high in cycle N+2. A fault detected in IDLE gives memDone in cycle N+1.
- Store lane placement:
  - SB replicates byte [7:0] to all lanes; bus_be = 0001 << addr[1:0].
  - SH replicates [15:0] to both halves; bus_be = 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - SW: bus_be = 1111.
- Reads always drive bus_be = 1111.
- Load extraction:
  - LB/LBU select the byte at addr[1:0], then sign- or zero-extend.
  - LH/LHU select the half at addr[1], then sign- or zero-extend.
  - LW passes the word through.
- Protocol rules:
  - New requests are ignored outside IDLE; the core holds them while memBusy is high.
  - bus_ack outside BUS is ignored.
  - An ack on the same edge the counter reaches timeout completes successfully; ack wins.
  - A request present in the DONE cycle is not accepted. It is taken in the following IDLE cycle.

Test Plan:
- Reset sequence: hold RES = 0 across a clock edge, then release; expect all outputs 0. Pulse RES low while in BUS; bus_req must fall immediately and no memDone may follow.
- Store byte: SB, addr 0x1003, memDataIn 0x000000A5, ack in 1st cycle. Expect bus_addr 0x1000, bus_wdata 0xA5A5A5A5, bus_be 1000, bus_we 1, memDone 2 cycles after the request, memFault 0.
- Load sign extension: bus_rdata 0x80FF7F01 with ack after 3 wait cycles. Expect:
  - LB @+1: 0x0000007F.
  - LB @+2: 0xFFFFFFFF.
  - LBU @+3: 0x00000080.
  - LH @+2: 0xFFFF80FF.
  - LHU @+0: 0x00007F01.
  - memBusy high for 5 cycles each.
- Misaligned access: LW 0x2002. Expect no bus_req, memDone next cycle, memFault 1, faultCause 01, faultAddr 0x00002002.
- Illegal request: memRead = memWrite = 1, or memSize 011. Expect cause 11 and no bus activity.
- Timeout: TIMEOUT_CYCLES = 4, bus_ack never asserted. Expect bus_req high for 4 cycles, then memDone, faultCause 10, memDataOut 0. Repeat with ack on the 4th cycle: success, cause 00.
